// File: rtl/min_tree_pkg.sv
// Shared definitions for the min_tree_pipe extreme-value selector.
//
// Contents:
//   MODE_MIN / MODE_MAX  values of in_mode / out_mode
//   clog2()              ceiling log2, used for index width and tree depth
//
// The tree node record {valid, data[W], idx[IDX_W], tie} depends on the
// module parameters W and IDX_W, so it is declared as node_t inside
// min_tree_pipe (a package cannot carry parameterised types). The field
// order below is the order used there; NODE_FIELDS documents it.
//
// Optional build macro: MIN_TREE_SIGNED_EN (see min_tree_node).
package min_tree_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Field order of the per-node record: valid, data, idx, tie.
    localparam int NODE_FIELDS = 4;

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/min_tree_pipe_if.sv
// Handshake bundle for min_tree_pipe.
//
// Valid/ready semantics (both sides): a beat transfers on the rising clock
// edge where valid and ready are both high. A source holding valid high must
// keep its payload stable until that edge; ready may be high or low freely
// and does not depend on valid.
//
// Signals:
//   in_valid / in_ready    input beat handshake
//   in_data [N_IN*W]       channel i at [i*W +: W]
//   in_mode                0 = min, 1 = max, travels with the beat
//   out_valid / out_ready  result handshake
//   out_data [W]           winning channel value
//   out_idx [IDX_W]        winning channel index
//   out_tie                two or more channels hold the extreme value
//   out_mode               mode the result was computed with
//
// Modports: master = producer/consumer side (testbench, system),
//           slave  = the selector block.
interface min_tree_pipe_if
    import min_tree_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int W    = 8
);
    localparam int IDX_W = clog2(N_IN);

    logic                in_valid;
    logic                in_ready;
    logic [N_IN*W-1:0]   in_data;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_tie;
    logic                out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_tie, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_tie, out_mode
    );

endinterface

// File: rtl/min_tree_node.sv
// Combinational 2-input compare cell of the extreme-value tree.
//
// Ports:
//   mode                          0 = min, 1 = max
//   a_valid/a_data/a_idx/a_tie    left (lower-index) node
//   b_valid/b_data/b_idx/b_tie    right (higher-index) node
//   y_valid/y_data/y_idx/y_tie    winning node
//
// Rules: with both nodes valid, b wins only when strictly better, so equal
// values resolve to the lower index and set tie. With one valid node it wins
// and keeps its own tie. With none valid the output is invalid.
//
// Build macro MIN_TREE_SIGNED_EN: compare as two's-complement signed.
// Default: unsigned compare.
module min_tree_node
    import min_tree_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = 2
) (
    input  logic             mode,
    input  logic             a_valid,
    input  logic [W-1:0]     a_data,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             a_tie,
    input  logic             b_valid,
    input  logic [W-1:0]     b_data,
    input  logic [IDX_W-1:0] b_idx,
    input  logic             b_tie,
    output logic             y_valid,
    output logic [W-1:0]     y_data,
    output logic [IDX_W-1:0] y_idx,
    output logic             y_tie
);
    logic b_lt;
    logic b_gt;
    logic equal;
    logic b_better;
    logic pick_b;

`ifdef MIN_TREE_SIGNED_EN
    assign b_lt = $signed(b_data) < $signed(a_data);
    assign b_gt = $signed(b_data) > $signed(a_data);
`else
    assign b_lt = b_data < a_data;
    assign b_gt = b_data > a_data;
`endif

    assign equal    = (a_data == b_data);
    assign b_better = (mode == MODE_MAX) ? b_gt : b_lt;

    always_comb begin
        pick_b = 1'b0;
        y_tie  = 1'b0;
        if (a_valid && b_valid) begin
            pick_b = b_better;
            y_tie  = equal ? 1'b1 : (b_better ? b_tie : a_tie);
        end else if (b_valid) begin
            pick_b = 1'b1;
            y_tie  = b_tie;
        end else if (a_valid) begin
            y_tie  = a_tie;
        end
    end

    assign y_valid = a_valid | b_valid;
    assign y_data  = pick_b ? b_data : a_data;
    assign y_idx   = pick_b ? b_idx  : a_idx;

endmodule

// File: rtl/min_tree_pipe.sv
// Pipelined extreme-value (min or max) selector over N_IN channels of W bits.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset; clears every stage, in_ready low
//   bus    min_tree_pipe_if.slave: in_* beat in, out_* result out
//          (the interface instance must use the same N_IN and W)
//
// Structure: N_IN is padded to 2**LVL leaves; pad leaves are invalid nodes
// and can never win. Tree level k (k = 0..LVL-1) is a row of min_tree_node
// cells whose results are registered in stage k together with a stage valid
// and the beat's mode, so the result appears LVL cycles after acceptance.
//
// Flow control: stage k loads when it is empty or its content moves on;
// the last stage moves on out_ready. This lets bubbles collapse under
// backpressure and keeps out_* frozen while out_valid & ~out_ready.
//
// Build macro MIN_TREE_SIGNED_EN: signed channel compare (in min_tree_node).
module min_tree_pipe
    import min_tree_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    min_tree_pipe_if.slave    bus
);
    localparam int IDX_W = clog2(N_IN);
    localparam int LVL   = clog2(N_IN);
    localparam int P     = 1 << LVL;

    typedef struct packed {
        logic             valid;
        logic [W-1:0]     data;
        logic [IDX_W-1:0] idx;
        logic             tie;
    } node_t;

    node_t        leaf [P];
    logic [LVL-1:0] v;          // stage valids
    logic [LVL:0]   ld;         // ld[k]: stage k may load; ld[LVL] = out_ready
    logic         in_ready;
    logic         in_fire;
    node_t        res;
    logic         res_mode;

    // Leaves: real channels carry their own index, pads are invalid.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N_IN) begin : g_real
            assign leaf[i] = '{valid: 1'b1, data: bus.in_data[i*W +: W],
                               idx: IDX_W'(i), tie: 1'b0};
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // A stage can load if it is empty or the stage after it can load.
    always_comb begin
        ld      = '0;
        ld[LVL] = bus.out_ready;
        for (int k = LVL - 1; k >= 0; k--) begin
            ld[k] = ~v[k] | ld[k+1];
        end
    end

    assign in_ready     = ~rst & ld[0];
    assign in_fire      = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;

    for (genvar k = 0; k < LVL; k++) begin : g_stg
        localparam int CNT = P >> (k + 1);

        node_t src [2*CNT];
        node_t d   [CNT];
        node_t q   [CNT];
        logic  src_valid;
        logic  src_mode;
        logic  vq;
        logic  mq;

        if (k == 0) begin : g_from_in
            assign src_valid = in_fire;
            assign src_mode  = bus.in_mode;
            for (genvar j = 0; j < 2*CNT; j++) begin : g_src
                assign src[j] = leaf[j];
            end
        end else begin : g_from_stg
            assign src_valid = g_stg[k-1].vq;
            assign src_mode  = g_stg[k-1].mq;
            for (genvar j = 0; j < 2*CNT; j++) begin : g_src
                assign src[j] = g_stg[k-1].q[j];
            end
        end

        for (genvar j = 0; j < CNT; j++) begin : g_node
            logic             y_valid;
            logic [W-1:0]     y_data;
            logic [IDX_W-1:0] y_idx;
            logic             y_tie;

            min_tree_node #(
                .W     (W),
                .IDX_W (IDX_W)
            ) u_node (
                .mode    (src_mode),
                .a_valid (src[2*j].valid),
                .a_data  (src[2*j].data),
                .a_idx   (src[2*j].idx),
                .a_tie   (src[2*j].tie),
                .b_valid (src[2*j+1].valid),
                .b_data  (src[2*j+1].data),
                .b_idx   (src[2*j+1].idx),
                .b_tie   (src[2*j+1].tie),
                .y_valid (y_valid),
                .y_data  (y_data),
                .y_idx   (y_idx),
                .y_tie   (y_tie)
            );

            assign d[j] = '{valid: y_valid, data: y_data, idx: y_idx, tie: y_tie};
        end

        // Payload only loads with a real beat so an idle stage keeps its
        // last value instead of tracking the input bus.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vq <= 1'b0;
                mq <= 1'b0;
                for (int j = 0; j < CNT; j++) begin
                    q[j] <= '0;
                end
            end else if (ld[k]) begin
                vq <= src_valid;
                if (src_valid) begin
                    mq <= src_mode;
                    for (int j = 0; j < CNT; j++) begin
                        q[j] <= d[j];
                    end
                end
            end
        end

        assign v[k] = vq;

        if (k == LVL - 1) begin : g_out
            assign res      = q[0];
            assign res_mode = mq;
        end
    end

    assign bus.out_valid = v[LVL-1];
    assign bus.out_data  = res.data;
    assign bus.out_idx   = res.idx;
    assign bus.out_tie   = res.tie;
    assign bus.out_mode  = res_mode;

endmodule

// File: tb/tb_min_tree_pipe.sv
// Self-checking bench for min_tree_pipe: a 4-channel and a 5-channel
// instance (W=8) driven from valid/ready driver tasks, with a reference
// model that finds the extreme value by scanning the channel list.
// Expected results are packed {mode, tie, idx[3:0], data[7:0]}.
module tb_min_tree_pipe;

    localparam int EW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [EW-1:0] exp4_q[$];
    logic [EW-1:0] exp5_q[$];
    int            out_cyc4[$];
    logic          stall4 = 1'b0;
    logic [EW-1:0] held4 = '0;
    logic          saw_block4 = 1'b0;
    logic          rand_done = 1'b0;
    logic [31:0]   dv4;
    logic [39:0]   dv5;
    int            lat;

    min_tree_pipe_if #(.N_IN(4), .W(8)) bus4 ();
    min_tree_pipe_if #(.N_IN(5), .W(8)) bus5 ();

    min_tree_pipe #(.N_IN(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    min_tree_pipe #(.N_IN(5), .W(8)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int key(input logic [7:0] x);
`ifdef MIN_TREE_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    // Scan channels 0..n-1: first strictly-better value wins, tie when the
    // winning value occurs more than once.
    function automatic logic [EW-1:0] ref_result(input logic [7:0] ch [8], input int n,
                                                 input logic mode);
        int best = 0;
        int cnt = 0;
        for (int i = 1; i < n; i++) begin
            if (mode ? (key(ch[i]) > key(ch[best])) : (key(ch[i]) < key(ch[best])))
                best = i;
        end
        for (int i = 0; i < n; i++) begin
            if (ch[i] == ch[best]) cnt++;
        end
        return {mode, (cnt > 1), 4'(best), ch[best]};
    endfunction

    function automatic logic [EW-1:0] ref4(input logic [31:0] data, input logic mode);
        logic [7:0] ch [8];
        for (int i = 0; i < 8; i++) ch[i] = 8'h00;
        for (int i = 0; i < 4; i++) ch[i] = data[i*8 +: 8];
        return ref_result(ch, 4, mode);
    endfunction

    function automatic logic [EW-1:0] ref5(input logic [39:0] data, input logic mode);
        logic [7:0] ch [8];
        for (int i = 0; i < 8; i++) ch[i] = 8'h00;
        for (int i = 0; i < 5; i++) ch[i] = data[i*8 +: 8];
        return ref_result(ch, 5, mode);
    endfunction

    // ---------------- drivers ----------------
    // Present one beat and hold it until accepted. The expected result is
    // either the given constant or the model's answer.
    task automatic send4(input logic [31:0] data, input logic mode,
                         input logic use_exp, input logic [EW-1:0] exp);
        int waited = 0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = data;
        bus4.in_mode  = mode;
        @(negedge clk);
        while (!bus4.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus4.in_ready) check("accept_timeout4", 0, 1);
        else exp4_q.push_back(use_exp ? exp : ref4(data, mode));
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic send5(input logic [39:0] data, input logic mode,
                         input logic use_exp, input logic [EW-1:0] exp);
        int waited = 0;
        bus5.in_valid = 1'b1;
        bus5.in_data  = data;
        bus5.in_mode  = mode;
        @(negedge clk);
        while (!bus5.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus5.in_ready) check("accept_timeout5", 0, 1);
        else exp5_q.push_back(use_exp ? exp : ref5(data, mode));
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b0;
    endtask

    task automatic drain4();
        int n = 0;
        while (exp4_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain4", exp4_q.size(), 0);
    endtask

    task automatic drain5();
        int n = 0;
        while (exp5_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain5", exp5_q.size(), 0);
    endtask

    // ---------------- scoreboards ----------------
    wire [EW-1:0] cur4 = {bus4.out_mode, bus4.out_tie, 2'b00, bus4.out_idx, bus4.out_data};
    wire [EW-1:0] cur5 = {bus5.out_mode, bus5.out_tie, 1'b0, bus5.out_idx, bus5.out_data};

    always @(negedge clk) begin
        if (rst) begin
            stall4 = 1'b0;
        end else begin
            if (stall4) begin
                check("hold_valid4", bus4.out_valid, 1);
                check("hold_result4", cur4, held4);
            end
            if (bus4.in_valid && !bus4.in_ready) saw_block4 = 1'b1;
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp4_q.size() == 0) begin
                    check("unexpected_out4", cur4, '1);
                end else begin
                    check("result4", cur4, exp4_q.pop_front());
                    out_cyc4.push_back(cyc);
                end
            end
            stall4 = bus4.out_valid && !bus4.out_ready;
            held4  = cur4;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus5.out_valid && bus5.out_ready) begin
            if (exp5_q.size() == 0) check("unexpected_out5", cur5, '1);
            else check("result5", cur5, exp5_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = 1'b0; bus4.out_ready = 1'b1;
        bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.in_mode = 1'b0; bus5.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_in_ready", bus4.in_ready, 0);
        check("rst_out_data", bus4.out_data, 0);
        check("rst_out_idx", bus4.out_idx, 0);
        check("rst_out_tie", bus4.out_tie, 0);
        check("rst_out_mode", bus4.out_mode, 0);
        check("rst_out_valid5", bus5.out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Min with latency measurement
        send4({8'd40, 8'd20, 8'd10, 8'd30}, 1'b0, 1'b1, {1'b0, 1'b0, 4'd1, 8'd10});
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency4", lat, 2);
        drain4();

        // Ties, max, sign-dependent ordering
        send4({8'd9, 8'd3, 8'd3, 8'd7}, 1'b0, 1'b1, {1'b0, 1'b1, 4'd1, 8'd3});
        send4({8'd9, 8'd9, 8'd9, 8'd9}, 1'b1, 1'b1, {1'b1, 1'b1, 4'd0, 8'd9});
        send4({8'd40, 8'd20, 8'd10, 8'd30}, 1'b1, 1'b1, {1'b1, 1'b0, 4'd3, 8'd40});
`ifdef MIN_TREE_SIGNED_EN
        send4({8'h00, 8'h7F, 8'h01, 8'hFF}, 1'b0, 1'b1, {1'b0, 1'b0, 4'd0, 8'hFF});
        send4({8'h00, 8'h7F, 8'h01, 8'hFF}, 1'b1, 1'b1, {1'b1, 1'b0, 4'd2, 8'h7F});
`else
        send4({8'h00, 8'h7F, 8'h01, 8'hFF}, 1'b0, 1'b1, {1'b0, 1'b0, 4'd3, 8'h00});
        send4({8'h00, 8'h7F, 8'h01, 8'hFF}, 1'b1, 1'b1, {1'b1, 1'b0, 4'd0, 8'hFF});
`endif
        drain4();

        // Back-to-back stream, alternating mode
        out_cyc4.delete();
        saw_block4 = 1'b0;
        for (int i = 0; i < 8; i++) send4($urandom, 1'(i % 2), 1'b0, '0);
        drain4();
        check("stream_count", out_cyc4.size(), 8);
        check("stream_span", out_cyc4[7] - out_cyc4[0], 7);
        check("stream_no_block", saw_block4, 0);

        // Backpressure mid-stream
        saw_block4 = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send4($urandom, 1'($urandom_range(0, 1)), 1'b0, '0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus4.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus4.out_ready = 1'b1;
            end
        join
        drain4();
        check("bp_in_ready_dropped", saw_block4, 1);

        // Randomized traffic with random gaps and random out_ready
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        for (int c = 0; c < 4; c++) dv4[c*8 +: 8] = 8'($urandom_range(0, 3)) - 8'd2;
                    end else begin
                        dv4 = $urandom;
                    end
                    send4(dv4, 1'($urandom_range(0, 1)), 1'b0, '0);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus4.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus4.out_ready = 1'b1;
        drain4();

        // Non-power-of-2 instance
        send5({8'd5, 8'd80, 8'd70, 8'd60, 8'd50}, 1'b0, 1'b1, {1'b0, 1'b0, 4'd4, 8'd5});
        lat = 1;
        while (!bus5.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency5", lat, 3);
        drain5();
        send5({8'd5, 8'd9, 8'd9, 8'd9, 8'd5}, 1'b0, 1'b1, {1'b0, 1'b1, 4'd0, 8'd5});
        send5({8'd60, 8'd50, 8'd40, 8'd30, 8'd20}, 1'b0, 1'b1, {1'b0, 1'b0, 4'd0, 8'd20});
        send5({8'd60, 8'd50, 8'd40, 8'd30, 8'd20}, 1'b1, 1'b1, {1'b1, 1'b0, 4'd4, 8'd60});
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 5; c++) dv5[c*8 +: 8] = 8'($urandom_range(0, 255));
            send5(dv5, 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        drain5();

        // Reset with two beats in flight
        bus4.out_ready = 1'b0;
        send4(32'h11223344, 1'b1, 1'b0, '0);
        send4(32'h55667788, 1'b1, 1'b0, '0);
        check("pre_rst_valid", bus4.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus4.out_valid, 0);
        check("midrst_out_data", bus4.out_data, 0);
        check("midrst_out_idx", bus4.out_idx, 0);
        check("midrst_out_tie", bus4.out_tie, 0);
        check("midrst_out_mode", bus4.out_mode, 0);
        check("midrst_in_ready", bus4.in_ready, 0);
        exp4_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", bus4.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send4({8'd8, 8'd6, 8'd200, 8'd6}, 1'b0, 1'b1, {1'b0, 1'b1, 4'd0, 8'd6});
        drain4();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
